// File: rtl/pipe_dest_tracker_if.sv
// Bundle between the ID/hazard side and the destination-tag tracker.
// The master drives ID tags and hazard responses; the slave drives the stage tags and status.
interface pipe_dest_tracker_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
);
  logic [RA_W-1:0]  RW_ID;
  logic             enable_RF_ID;
  logic             enable_LD_ID;
  logic             valid_ID;
  logic             CU_Sel;
  logic             Hazard_load_in;
  logic             flush;

  logic [RA_W-1:0]  RW_EX;
  logic [RA_W-1:0]  RW_MEM;
  logic [RA_W-1:0]  RW_WB;
  logic             enable_LD_EX;
  logic             enable_RF_EX;
  logic             enable_RF_MEM;
  logic             enable_RF_WB;
  logic             wb_retire;
  logic             proto_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output RW_ID, enable_RF_ID, enable_LD_ID, valid_ID, CU_Sel, Hazard_load_in, flush,
    input  RW_EX, RW_MEM, RW_WB, enable_LD_EX, enable_RF_EX, enable_RF_MEM, enable_RF_WB,
           wb_retire, proto_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  RW_ID, enable_RF_ID, enable_LD_ID, valid_ID, CU_Sel, Hazard_load_in, flush,
    output RW_EX, RW_MEM, RW_WB, enable_LD_EX, enable_RF_EX, enable_RF_MEM, enable_RF_WB,
           wb_retire, proto_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_dest_tracker.sv
// Carries each in-flight instruction's destination tag from ID through EX, MEM and WB,
// applies load-use bubbles and flushes, and polices the hazard unit's stall protocol.
module pipe_dest_tracker #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_dest_tracker_if.slave   bus
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rw;
    logic            en_rf;
    logic            en_ld;
  } stage_t;

  stage_t           ex_q;
  stage_t           mem_q;
  stage_t           wb_q;
  logic             cu_sel_q;
  logic             proto_err_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             proto_viol;

  // Any of the three stall-protocol violations, judged on pre-update state.
  assign proto_viol = (bus.CU_Sel != ~bus.Hazard_load_in)
                    | (bus.CU_Sel & ~bus.enable_LD_EX)
                    | (bus.CU_Sel & cu_sel_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      cu_sel_q    <= 1'b0;
      proto_err_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bus.flush || bus.CU_Sel) begin
        ex_q <= '0;
      end else begin
        ex_q.valid <= bus.valid_ID;
        ex_q.rw    <= bus.RW_ID;
        ex_q.en_rf <= bus.enable_RF_ID & bus.valid_ID;
        ex_q.en_ld <= bus.enable_LD_ID & bus.valid_ID;
      end
      cu_sel_q <= bus.CU_Sel;
      if (proto_viol) begin
        proto_err_q <= 1'b1;
      end
      if (bus.CU_Sel && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (bus.flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  // Invalid stages present an all-zero tag so the hazard unit never matches a bubble.
  assign bus.RW_EX         = ex_q.valid  ? ex_q.rw  : '0;
  assign bus.RW_MEM        = mem_q.valid ? mem_q.rw : '0;
  assign bus.RW_WB         = wb_q.valid  ? wb_q.rw  : '0;
  assign bus.enable_LD_EX  = ex_q.valid  & ex_q.en_ld;
  assign bus.enable_RF_EX  = ex_q.valid  & ex_q.en_rf;
  assign bus.enable_RF_MEM = mem_q.valid & mem_q.en_rf;
  assign bus.enable_RF_WB  = wb_q.valid  & wb_q.en_rf;
  assign bus.wb_retire     = wb_q.valid;
  assign bus.proto_err     = proto_err_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Scoreboard bench for pipe_dest_tracker: directed vectors push hand-derived expectations,
// a negedge monitor pops and compares them against the stage outputs.
module tb_pipe_dest_tracker;

  typedef struct packed {
    logic [3:0] rw_ex;
    logic       rf_ex;
    logic       ld_ex;
    logic [3:0] rw_mem;
    logic       rf_mem;
    logic [3:0] rw_wb;
    logic       rf_wb;
    logic       retire;
    logic       perr;
    logic [2:0] scnt;
    logic [2:0] fcnt;
  } out_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  out_t exp_q[$];
  int   id_q[$];

  pipe_dest_tracker_if #(.RA_W(4), .CNT_W(3)) bus ();

  pipe_dest_tracker #(.RA_W(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(input logic [3:0] rw_ex, input logic rf_ex, input logic ld_ex,
                              input logic [3:0] rw_mem, input logic rf_mem,
                              input logic [3:0] rw_wb, input logic rf_wb, input logic retire,
                              input logic perr, input int scnt, input int fcnt);
    out_t o;
    o.rw_ex  = rw_ex;
    o.rf_ex  = rf_ex;
    o.ld_ex  = ld_ex;
    o.rw_mem = rw_mem;
    o.rf_mem = rf_mem;
    o.rw_wb  = rw_wb;
    o.rf_wb  = rf_wb;
    o.retire = retire;
    o.perr   = perr;
    o.scnt   = 3'(scnt);
    o.fcnt   = 3'(fcnt);
    return o;
  endfunction

  task automatic checkOutput(input int id, input out_t want);
    out_t got;
    got.rw_ex  = bus.RW_EX;
    got.rf_ex  = bus.enable_RF_EX;
    got.ld_ex  = bus.enable_LD_EX;
    got.rw_mem = bus.RW_MEM;
    got.rf_mem = bus.enable_RF_MEM;
    got.rw_wb  = bus.RW_WB;
    got.rf_wb  = bus.enable_RF_WB;
    got.retire = bus.wb_retire;
    got.perr   = bus.proto_err;
    got.scnt   = bus.stall_cnt;
    got.fcnt   = bus.flush_cnt;
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL vec%0d: got ex=%h/%b%b mem=%h/%b wb=%h/%b ret=%b err=%b st=%0d fl=%0d, want ex=%h/%b%b mem=%h/%b wb=%h/%b ret=%b err=%b st=%0d fl=%0d",
               id, got.rw_ex, got.rf_ex, got.ld_ex, got.rw_mem, got.rf_mem, got.rw_wb, got.rf_wb,
               got.retire, got.perr, got.scnt, got.fcnt,
               want.rw_ex, want.rf_ex, want.ld_ex, want.rw_mem, want.rf_mem, want.rw_wb, want.rf_wb,
               want.retire, want.perr, want.scnt, want.fcnt);
    end
  endtask

  task automatic drive(input logic [3:0] rw, input logic rf, input logic ld, input logic vld,
                       input logic cu, input logic hl, input logic fl);
    bus.RW_ID          = rw;
    bus.enable_RF_ID   = rf;
    bus.enable_LD_ID   = ld;
    bus.valid_ID       = vld;
    bus.CU_Sel         = cu;
    bus.Hazard_load_in = hl;
    bus.flush          = fl;
  endtask

  // Expected value describes the outputs right after the next rising edge.
  task automatic applyStimulus(input int id, input logic [3:0] rw, input logic rf, input logic ld,
                               input logic vld, input logic cu, input logic hl, input logic fl,
                               input out_t want);
    drive(rw, rf, ld, vld, cu, hl, fl);
    @(posedge clk);
    exp_q.push_back(want);
    id_q.push_back(id);
    #1;
  endtask

  task automatic drainQueue();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock edge.
  task automatic pulseReset(input int id);
    drainQueue();
    reset = 1'b1;
    #1;
    checkOutput(id, mk(0,0,0, 0,0, 0,0,0, 0,0,0));
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t w;
      int   id;
      w  = exp_q.pop_front();
      id = id_q.pop_front();
      checkOutput(id, w);
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    checkOutput(0, mk(0,0,0, 0,0, 0,0,0, 0,0,0));
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Plain flow, PC tag, invalid-ID masking
    applyStimulus(1,  4'd3,  1,0,1, 0,1,0, mk(3,1,0,  0,0,  0,0,0, 0,0,0));
    applyStimulus(2,  4'd5,  1,0,1, 0,1,0, mk(5,1,0,  3,1,  0,0,0, 0,0,0));
    applyStimulus(3,  4'd15, 1,0,1, 0,1,0, mk(15,1,0, 5,1,  3,1,1, 0,0,0));
    applyStimulus(4,  4'd0,  1,0,0, 0,1,0, mk(0,0,0,  15,1, 5,1,1, 0,0,0));
    // Legal load-use stall
    applyStimulus(5,  4'd2,  1,1,1, 0,1,0, mk(2,1,1,  0,0,  15,1,1, 0,0,0));
    applyStimulus(6,  4'd4,  1,0,1, 1,0,0, mk(0,0,0,  2,1,  0,0,0, 0,1,0));
    applyStimulus(7,  4'd4,  1,0,1, 0,1,0, mk(4,1,0,  0,0,  2,1,1, 0,1,0));
    // Flush coinciding with a stall, then a lone flush
    applyStimulus(8,  4'd6,  1,1,1, 0,1,0, mk(6,1,1,  4,1,  0,0,0, 0,1,0));
    applyStimulus(9,  4'd7,  1,0,1, 1,0,1, mk(0,0,0,  6,1,  4,1,1, 0,2,1));
    applyStimulus(10, 4'd8,  1,0,1, 0,1,0, mk(8,1,0,  0,0,  6,1,1, 0,2,1));
    applyStimulus(11, 4'd9,  1,0,1, 0,1,0, mk(9,1,0,  8,1,  0,0,0, 0,2,1));
    applyStimulus(12, 4'd10, 1,0,1, 0,1,1, mk(0,0,0,  9,1,  8,1,1, 0,2,2));

    pulseReset(13);
    applyStimulus(14, 4'd1,  1,0,1, 0,1,0, mk(1,1,0,  0,0,  0,0,0, 0,0,0));
    // Stall without a load in EX
    applyStimulus(15, 4'd2,  1,0,1, 1,0,0, mk(0,0,0,  1,1,  0,0,0, 1,1,0));
    applyStimulus(16, 4'd2,  1,0,1, 0,1,0, mk(2,1,0,  0,0,  1,1,1, 1,1,0));

    pulseReset(17);
    // Inconsistent hazard outputs
    applyStimulus(18, 4'd3,  1,0,1, 0,0,0, mk(3,1,0,  0,0,  0,0,0, 1,0,0));
    applyStimulus(19, 4'd0,  0,0,0, 0,1,0, mk(0,0,0,  3,1,  0,0,0, 1,0,0));

    pulseReset(20);
    // Two consecutive stall cycles
    applyStimulus(21, 4'd2,  1,1,1, 0,1,0, mk(2,1,1,  0,0,  0,0,0, 0,0,0));
    applyStimulus(22, 4'd4,  1,0,1, 1,0,0, mk(0,0,0,  2,1,  0,0,0, 0,1,0));
    applyStimulus(23, 4'd4,  1,0,1, 1,0,0, mk(0,0,0,  0,0,  2,1,1, 1,2,0));
    applyStimulus(24, 4'd0,  0,0,0, 0,1,0, mk(0,0,0,  0,0,  0,0,0, 1,2,0));

    pulseReset(25);
    // Saturation of stall_cnt, alternating legal stalls
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(100 + 2*k, 4'd2, 1,1,1, 0,1,0,
                    mk(2,1,1, 0,0, (k > 1) ? 4'd2 : 4'd0, k > 1, k > 1, 0, (k - 1 > 7) ? 7 : k - 1, 0));
      applyStimulus(101 + 2*k, 4'd2, 1,1,1, 1,0,0,
                    mk(0,0,0, 2,1, 0,0,0, 0, (k > 7) ? 7 : k, 0));
    end
    // Saturation of flush_cnt
    for (int j = 1; j <= 9; j++) begin
      applyStimulus(200 + j, 4'd0, 0,0,0, 0,1,1,
                    mk(0,0,0, 0,0, (j == 1) ? 4'd2 : 4'd0, j == 1, j == 1, 0, 7, (j > 7) ? 7 : j));
    end

    drainQueue();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
